// File: rtl/ofm_pkg.sv
// Shared types and helpers for the output feature-map bank buffer.
package ofm_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_CLEAR,
      S_RUN,
      S_FLUSH,
      S_DRAIN
   } ofm_state_t;

   localparam int DEF_DATA_W = 32;
   localparam int DEF_DEPTH  = 512;
   localparam int DEF_NUM_CH = 2;

   // Width of a select field that must stay at least one bit wide.
   function automatic int clog2_min1(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/ofm_bank_ram.sv
// One output-channel bank: 1R1W synchronous RAM, read-first, 1-cycle read latency.
module ofm_bank_ram #(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 512,
   parameter int ADR_W  = 9
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADR_W-1:0]  wadr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [ADR_W-1:0]  radr,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem [DEPTH];

   // A read of the address being written returns the old word; the top bypasses it.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[wadr] <= wdata;
      end
      rdata <= mem[radr];
   end

endmodule

// File: rtl/ofm_bank_buffer.sv
// Output feature-map buffer: NUM_CH banks with write/accumulate pipeline and
// a channel-major valid/ready drain port.
module ofm_bank_buffer
   import ofm_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int DEPTH  = DEF_DEPTH,
   parameter int NUM_CH = DEF_NUM_CH,
   parameter int ADR_W  = clog2_min1(DEPTH),
   parameter int CH_W   = clog2_min1(NUM_CH)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              we,
   input  logic              acc,
   input  logic [CH_W-1:0]   ch,
   input  logic [ADR_W-1:0]  adr,
   input  logic [DATA_W-1:0] in,
   input  logic              done,
   output logic              wr_ready,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [CH_W-1:0]   out_ch,
   output logic [ADR_W-1:0]  out_adr,
   output logic              out_last,
   output logic              drained,
   output logic              err
);

   localparam logic [ADR_W-1:0] LAST_ADR = ADR_W'(DEPTH - 1);
   localparam logic [CH_W-1:0]  LAST_CH  = CH_W'(NUM_CH - 1);

   function automatic logic [DATA_W-1:0] wrap_add(input logic [DATA_W-1:0] a,
                                                  input logic [DATA_W-1:0] b);
      return a + b;
   endfunction

   ofm_state_t state;
   ofm_state_t state_d;

   logic              vld_p0;
   logic              acc_p0;
   logic [CH_W-1:0]   ch_p0;
   logic [ADR_W-1:0]  adr_p0;
   logic [DATA_W-1:0] in_p0;
   logic              vld_p1;
   logic [CH_W-1:0]   ch_p1;
   logic [ADR_W-1:0]  adr_p1;
   logic [DATA_W-1:0] res_p1;

   logic [ADR_W-1:0]  clr_adr;
   logic [CH_W-1:0]   iss_ch;
   logic [ADR_W-1:0]  iss_adr;
   logic [ADR_W-1:0]  radr;
   logic [DATA_W-1:0] rdata [NUM_CH];
   logic [DATA_W-1:0] old_p0;
   logic [DATA_W-1:0] res_p0;
   logic              wr_ok;
   logic              fetch_ok;
   logic              last_acc;

   assign wr_ready = (state == S_RUN);
   assign wr_ok    = we && wr_ready && (adr <= LAST_ADR) && (ch <= LAST_CH);
   assign fetch_ok = !out_valid || out_ready;
   assign last_acc = out_valid && out_ready && out_last;
   assign out_data = out_valid ? rdata[out_ch] : '0;

   // The word written last cycle is not yet visible in the RAM read, so forward it.
   assign old_p0 = (vld_p1 && (ch_p1 == ch_p0) && (adr_p1 == adr_p0)) ? res_p1 : rdata[ch_p0];
   assign res_p0 = acc_p0 ? wrap_add(old_p0, in_p0) : in_p0;

   // While a beat is stalled, re-read its own address so the RAM output holds.
   always_comb begin
      radr = adr;
      if (state == S_DRAIN) begin
         radr = fetch_ok ? iss_adr : out_adr;
      end
   end

   always_comb begin
      state_d = state;
      if (start) begin
         state_d = S_CLEAR;
      end else begin
         case (state)
            S_CLEAR: if (clr_adr == LAST_ADR) state_d = S_RUN;
            S_RUN:   if (done) state_d = S_FLUSH;
            S_FLUSH: if (!vld_p0) state_d = S_DRAIN;
            S_DRAIN: if (last_acc) state_d = S_IDLE;
            default: state_d = state;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_d;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         vld_p0    <= 1'b0;
         vld_p1    <= 1'b0;
         err       <= 1'b0;
         clr_adr   <= '0;
         iss_ch    <= '0;
         iss_adr   <= '0;
         out_valid <= 1'b0;
         out_last  <= 1'b0;
         out_ch    <= '0;
         out_adr   <= '0;
         drained   <= 1'b0;
      end else begin
         drained <= 1'b0;
         vld_p0  <= wr_ok && !start;
         vld_p1  <= vld_p0 && !start;
         if (start) begin
            err       <= 1'b0;
            clr_adr   <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_ch    <= '0;
            out_adr   <= '0;
         end else begin
            if (we && !wr_ok) begin
               err <= 1'b1;
            end
            if (state == S_CLEAR) begin
               clr_adr <= clr_adr + ADR_W'(1);
            end
            if (state == S_FLUSH) begin
               iss_ch  <= '0;
               iss_adr <= '0;
            end
            if (state == S_DRAIN) begin
               if (last_acc) begin
                  out_valid <= 1'b0;
                  out_last  <= 1'b0;
                  drained   <= 1'b1;
               end else if (fetch_ok) begin
                  out_valid <= 1'b1;
                  out_ch    <= iss_ch;
                  out_adr   <= iss_adr;
                  out_last  <= (iss_ch == LAST_CH) && (iss_adr == LAST_ADR);
                  if (iss_adr == LAST_ADR) begin
                     iss_adr <= '0;
                     iss_ch  <= iss_ch + CH_W'(1);
                  end else begin
                     iss_adr <= iss_adr + ADR_W'(1);
                  end
               end
            end
         end
      end
   end

   // Stage 0 -> stage 1 boundary: request captured, bank read in flight.
   always_ff @(posedge clk) begin
      ch_p0  <= ch;
      adr_p0 <= adr;
      in_p0  <= in;
      acc_p0 <= acc;
      ch_p1  <= ch_p0;
      adr_p1 <= adr_p0;
      res_p1 <= res_p0;
   end

   for (genvar b = 0; b < NUM_CH; b++) begin : g_bank
      logic              bank_we;
      logic [ADR_W-1:0]  bank_wadr;
      logic [DATA_W-1:0] bank_wdata;

      always_comb begin
         bank_we    = 1'b0;
         bank_wadr  = adr_p0;
         bank_wdata = res_p0;
         if (state == S_CLEAR) begin
            bank_we    = 1'b1;
            bank_wadr  = clr_adr;
            bank_wdata = '0;
         end else if (vld_p0 && (ch_p0 == CH_W'(b))) begin
            bank_we = 1'b1;
         end
      end

      ofm_bank_ram #(
         .DATA_W(DATA_W),
         .DEPTH (DEPTH),
         .ADR_W (ADR_W)
      ) u_ram (
         .clk  (clk),
         .we   (bank_we),
         .wadr (bank_wadr),
         .wdata(bank_wdata),
         .radr (radr),
         .rdata(rdata[b])
      );
   end

endmodule

// File: tb/tb_ofm_bank_buffer.sv
// Randomised bench for ofm_bank_buffer against a word-array model of the banks.
module tb_ofm_bank_buffer;

   localparam int DW = 32;
   localparam int DP = 10;
   localparam int NC = 3;
   localparam int AW = 4;
   localparam int CW = 2;

   logic          clk;
   logic          rst;
   logic          start;
   logic          we;
   logic          acc_d;
   logic [CW-1:0] ch_d;
   logic [AW-1:0] adr_d;
   logic [DW-1:0] in_d;
   logic          done;
   logic          wr_ready;
   logic          out_valid;
   logic          out_ready;
   logic [DW-1:0] out_data;
   logic [CW-1:0] out_ch;
   logic [AW-1:0] out_adr;
   logic          out_last;
   logic          drained;
   logic          err;

   ofm_bank_buffer #(
      .DATA_W(DW),
      .DEPTH (DP),
      .NUM_CH(NC)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .we       (we),
      .acc      (acc_d),
      .ch       (ch_d),
      .adr      (adr_d),
      .in       (in_d),
      .done     (done),
      .wr_ready (wr_ready),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_data (out_data),
      .out_ch   (out_ch),
      .out_adr  (out_adr),
      .out_last (out_last),
      .drained  (drained),
      .err      (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int          c;
      int          a;
      logic [31:0] d;
      bit          last;
   } beat_t;

   typedef struct {
      int          c;
      int          a;
      logic [31:0] d;
      bit          ac;
      bit          dn;
      bit          gap;
   } wr_t;

   int checks = 0;
   int errors = 0;

   logic [DW-1:0] model_mem [NC][DP];
   bit            model_err;
   bit            model_run;
   beat_t         exp_q [$];
   wr_t           wq [$];

   logic [DW-1:0] cap [NC][DP];
   int            cyc = 0;
   int            n_beats = 0;
   int            t_first = -1;
   int            t_drained = 0;
   bit            drained_pend = 0;
   bit            drained_seen = 0;
   bit            prev_stall = 0;
   logic [CW+AW+DW-1:0] prev_beat;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, expv);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Single compare process for the drain port.
   always @(negedge clk) begin
      beat_t e;
      cyc++;
      if (!rst) begin
         chk("drained_pulse", drained, drained_pend);
         if (drained) begin
            drained_seen = 1;
            t_drained = cyc;
         end
         drained_pend = 0;
         if (out_valid) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_beat_valid", out_valid, 0);
            end else begin
               e = exp_q[0];
               if (t_first < 0) t_first = cyc;
               chk("beat", {out_ch, out_adr, out_data, out_last},
                   {CW'(e.c), AW'(e.a), e.d, e.last});
               if (prev_stall) chk("stall_hold", {out_ch, out_adr, out_data}, prev_beat);
               if (out_ready) begin
                  if (out_ch < NC && out_adr < DP) cap[out_ch][out_adr] = out_data;
                  n_beats++;
                  if (e.last) drained_pend = 1;
                  void'(exp_q.pop_front());
               end
            end
         end
         prev_stall = out_valid && !out_ready;
         prev_beat  = {out_ch, out_adr, out_data};
      end else begin
         drained_pend = 0;
         prev_stall   = 0;
      end
   end

   task automatic build_queue();
      beat_t b;
      exp_q.delete();
      for (int c = 0; c < NC; c++) begin
         for (int a = 0; a < DP; a++) begin
            b.c = c;
            b.a = a;
            b.d = model_mem[c][a];
            b.last = (c == NC - 1) && (a == DP - 1);
            exp_q.push_back(b);
         end
      end
      n_beats = 0;
      t_first = -1;
      drained_seen = 0;
   endtask

   task automatic drive_write(input int c, input int a, input logic [31:0] d,
                              input bit ac, input bit dn);
      chk("wr_ready", wr_ready, model_run);
      we = 1'b1;
      ch_d = CW'(c);
      adr_d = AW'(a);
      in_d = d;
      acc_d = ac;
      done = dn;
      tick();
      we = 1'b0;
      acc_d = 1'b0;
      done = 1'b0;
      if (model_run && a < DP && c < NC) begin
         model_mem[c][a] = ac ? model_mem[c][a] + d : d;
      end else begin
         model_err = 1;
      end
      chk("err_after_write", err, model_err);
      if (dn) begin
         model_run = 0;
         build_queue();
      end
   endtask

   task automatic pulse_start();
      int n;
      start = 1'b1;
      tick();
      start = 1'b0;
      exp_q.delete();
      for (int c = 0; c < NC; c++)
         for (int a = 0; a < DP; a++) model_mem[c][a] = '0;
      model_err = 0;
      model_run = 0;
      chk("err_cleared", err, 0);
      chk("valid_after_start", out_valid, 0);
      n = 0;
      while (!wr_ready && n < 100) begin
         tick();
         n++;
      end
      chk("clear_cycles", n, DP);
      model_run = 1;
   endtask

   task automatic do_done();
      done = 1'b1;
      tick();
      done = 1'b0;
      model_run = 0;
      build_queue();
   endtask

   task automatic run_drain(input bit rnd, input int poke);
      for (int n = 0; n < 2000; n++) begin
         out_ready = rnd ? ($urandom_range(0, 99) < 30) : 1'b1;
         if (n == poke) begin
            we = 1'b1;
            ch_d = '0;
            adr_d = AW'(1);
            in_d = 32'h55;
         end else begin
            we = 1'b0;
         end
         tick();
         if (n == poke) model_err = 1;
         if (drained_seen) break;
      end
      we = 1'b0;
      out_ready = 1'b0;
      tick();
      chk("drain_done", drained_seen, 1);
      chk("beat_count", n_beats, NC * DP);
      chk("err_state", err, model_err);
   endtask

   task automatic replay();
      foreach (wq[i]) begin
         if (wq[i].gap) tick();
         drive_write(wq[i].c, wq[i].a, wq[i].d, wq[i].ac, wq[i].dn);
      end
   endtask

   task automatic add_wr(input int c, input int a, input logic [31:0] d,
                         input bit ac, input bit dn, input bit gap);
      wr_t w;
      w.c = c;
      w.a = a;
      w.d = d;
      w.ac = ac;
      w.dn = dn;
      w.gap = gap;
      wq.push_back(w);
   endtask

   initial begin
      rst = 1'b1;
      start = 1'b0;
      we = 1'b0;
      acc_d = 1'b0;
      ch_d = '0;
      adr_d = '0;
      in_d = '0;
      done = 1'b0;
      out_ready = 1'b0;
      model_err = 0;
      model_run = 0;
      repeat (3) tick();
      chk("rst_wr_ready", wr_ready, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_last", out_last, 0);
      chk("rst_drained", drained, 0);
      chk("rst_err", err, 0);
      chk("rst_out_fields", {out_data, out_ch, out_adr}, 0);
      rst = 1'b0;
      tick();

      // Clear then drain all zeros at full rate.
      pulse_start();
      do_done();
      run_drain(0, -1);
      chk("full_rate_span", t_drained - t_first, NC * DP);

      // Directed hazard/wrap writes plus random traffic, done with a final accumulate.
      add_wr(0, 3, 32'hDEADBEEF, 0, 0, 0);
      add_wr(0, 3, 32'h00000011, 1, 0, 0);
      add_wr(0, 3, 32'h00000001, 1, 0, 0);
      add_wr(1, 5, 32'hFFFFFFFF, 0, 0, 0);
      add_wr(1, 5, 32'h00000002, 1, 0, 0);
      add_wr(1, 0, 32'h00001000, 0, 0, 0);
      for (int i = 0; i < 40; i++) begin
         add_wr($urandom_range(0, NC - 1), $urandom_range(6, DP - 1), $urandom,
                $urandom_range(0, 1), 0, $urandom_range(0, 3) == 0);
      end
      add_wr(1, 0, 32'h00000234, 1, 1, 0);

      pulse_start();
      replay();
      chk("model_hazard", model_mem[0][3], 32'hDEADBF01);
      chk("model_wrap", model_mem[1][5], 32'h00000001);
      run_drain(0, 4);
      chk("drain_hazard_word", cap[0][3], 32'hDEADBF01);
      chk("drain_wrap_word", cap[1][5], 32'h00000001);
      chk("drain_done_acc_word", cap[1][0], 32'h00001234);

      // Same traffic with rejected writes and 30% backpressure.
      pulse_start();
      drive_write(0, 10, 32'h12345678, 0, 0);
      drive_write(3, 2, 32'h12345678, 0, 0);
      drive_write(1, 15, 32'h12345678, 1, 0);
      replay();
      run_drain(1, -1);
      chk("bp_hazard_word", cap[0][3], 32'hDEADBF01);
      chk("bp_wrap_word", cap[1][5], 32'h00000001);

      // Reset part-way through a drain.
      pulse_start();
      drive_write(0, 0, 32'h5, 0, 0);
      drive_write(0, 0, 32'h1, 1, 1);
      out_ready = 1'b1;
      for (int n = 0; n < 200 && n_beats < 5; n++) tick();
      chk("beats_before_rst", n_beats, 5);
      out_ready = 1'b0;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      exp_q.delete();
      model_run = 0;
      model_err = 0;
      chk("rst_abort_valid", out_valid, 0);
      chk("rst_abort_wr_ready", wr_ready, 0);
      chk("rst_abort_err", err, 0);
      repeat (6) tick();
      chk("rst_abort_no_drained", drained_seen, 0);

      // Start part-way through a drain, then a full zero drain.
      pulse_start();
      drive_write(2, 9, 32'h7, 0, 1);
      out_ready = 1'b1;
      for (int n = 0; n < 200 && n_beats < 3; n++) tick();
      chk("beats_before_start", n_beats, 3);
      out_ready = 1'b0;
      pulse_start();
      chk("start_abort_no_drained", drained_seen, 0);
      do_done();
      run_drain(0, -1);
      chk("post_abort_zero_last", cap[2][9], 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
